// File: rtl/demod_pkg.sv
// -----------------------------------------------------------------------------
// demod_pkg -- shared types and constants for the PRBS9 bit-error-rate checker.
//
// Contents:
//   state_e        : checker FSM state (SEARCH / LOCK)
//   PRBS_W         : PRBS9 register width
//   PRBS_TAP_HI/LO : register taps for x^9 + x^5 + 1 (bit 0 = newest bit)
//   LED_*          : status LED vector width and bit positions
//   prbs9_predict  : next PRBS9 bit predicted from the current register
// -----------------------------------------------------------------------------
package demod_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCK   = 1'b1
  } state_e;

  localparam int PRBS_W      = 9;
  localparam int PRBS_TAP_HI = 8;  // bit received 9 symbols ago
  localparam int PRBS_TAP_LO = 4;  // bit received 5 symbols ago

  localparam int LED_W        = 4;
  localparam int LED_LOCK     = 0;
  localparam int LED_LAST_ERR = 1;
  localparam int LED_ERR_NZ   = 2;
  localparam int LED_SAT      = 3;

  function automatic logic prbs9_predict(input logic [PRBS_W-1:0] s);
    return s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
  endfunction

endpackage : demod_pkg

// File: rtl/prbs9_lfsr.sv
// -----------------------------------------------------------------------------
// prbs9_lfsr -- 9-bit PRBS9 reference register with prediction output.
//
// The register holds the last nine reference bits, newest in bit 0. On each
// shift it either takes an external bit (self-synchronising search mode) or
// its own predicted bit (free-running reference mode).
//
// Ports:
//   clock      in   system clock, rising edge
//   i_reset    in   synchronous active-high reset (register cleared)
//   i_shift_en in   advance the register by one bit
//   i_load_ext in   1: shift in i_ext_bit, 0: shift in own prediction
//   i_ext_bit  in   externally supplied bit (received decision)
//   o_state    out  current register contents
//   o_pred     out  predicted next bit = state[8] ^ state[4]
// -----------------------------------------------------------------------------
module prbs9_lfsr
  import demod_pkg::*;
(
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_shift_en,
  input  logic              i_load_ext,
  input  logic              i_ext_bit,
  output logic [PRBS_W-1:0] o_state,
  output logic              o_pred
);

  logic [PRBS_W-1:0] state_q, state_d;
  logic              in_bit;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_pred  = prbs9_predict(state_q);
    in_bit  = i_load_ext ? i_ext_bit : o_pred;
    state_d = state_q;
    if (i_shift_en) begin
      state_d = {state_q[PRBS_W-2:0], in_bit};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule : prbs9_lfsr

// File: rtl/demod_ber.sv
// -----------------------------------------------------------------------------
// demod_ber -- oversampled hard-decision demodulator with PRBS9 BER checker.
//
// A free-running phase counter picks one sample per symbol (the strobe). The
// sign of that sample is the decision bit. In SEARCH the decisions are shifted
// into a PRBS9 register until LOCK_THR consecutive predictions hit; in LOCK
// the register free-runs and every decision is scored against it.
//
// Optional feature (macro DEMOD_BER_AUTO_RELOCK_EN):
//   defined   : errors are counted over WIN-bit windows; a window ending with
//               LOSS_THR or more errors drops back to SEARCH (counters kept).
//   undefined : no window logic, LOCK is held until reset.
//
// Parameters: OS (samples/symbol, 2..8), NB (sample width), CNT_W (counter
//   width), LOCK_THR, WIN, LOSS_THR.
//
// Ports:
//   clock      in   system clock, rising edge
//   i_reset    in   synchronous active-high reset, overrides i_enable
//   i_enable   in   advance enable; low freezes all state and outputs
//   i_phase    in   sampling phase within a symbol
//   i_sample   in   signed received sample, one per clock
//   o_lock     out  PRBS9 alignment achieved
//   o_bit_cnt  out  bits checked while locked (saturating)
//   o_err_cnt  out  bit errors while locked (saturating)
//   o_leds     out  [0] lock, [1] last decision errored,
//                   [2] error count nonzero, [3] a counter saturated (sticky)
// -----------------------------------------------------------------------------
module demod_ber
  import demod_pkg::*;
#(
  parameter int OS       = 4,
  parameter int NB       = 8,
  parameter int CNT_W    = 32,
  parameter int LOCK_THR = 32,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 16
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [$clog2(OS)-1:0] i_phase,
  input  logic [NB-1:0]         i_sample,
  output logic                  o_lock,
  output logic [CNT_W-1:0]      o_bit_cnt,
  output logic [CNT_W-1:0]      o_err_cnt,
  output logic [LED_W-1:0]      o_leds
);

  localparam int                PH_W    = $clog2(OS);
  localparam int                MATCH_W = $clog2(LOCK_THR + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(OS - 1);

  // Elaboration-time parameter sanity checks.
  if (OS < 2 || OS > 8) begin : g_bad_os
    $error("demod_ber: OS must be 2..8");
  end
  if (LOCK_THR < 1) begin : g_bad_lock_thr
    $error("demod_ber: LOCK_THR must be at least 1");
  end
  if (WIN < 1 || LOSS_THR > WIN) begin : g_bad_window
    $error("demod_ber: need WIN >= 1 and LOSS_THR <= WIN");
  end

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               last_err_q, last_err_d;
  logic               sat_q, sat_d;

  logic               strobe;
  logic               decision;
  logic               pred;
  logic               mismatch;
  logic               lfsr_zero;
  logic [PRBS_W-1:0]  lfsr_state;

`ifdef DEMOD_BER_AUTO_RELOCK_EN
  localparam int WIN_W = $clog2(WIN + 1);
  logic [WIN_W-1:0] win_bits_q, win_bits_d;
  logic [WIN_W-1:0] win_errs_q, win_errs_d;
`endif

  // ---------------------------------------------------------------------------
  // Symbol timing and decision
  // ---------------------------------------------------------------------------
  // The comparison uses the live i_phase, so a phase change takes effect on
  // the very next comparison without disturbing the counter.
  assign phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
  assign strobe   = i_enable && (phase_q == i_phase);
  assign decision = ($signed(i_sample) < $signed(NB'(0)));

  // ---------------------------------------------------------------------------
  // Reference register: self-synchronising in SEARCH, free-running in LOCK
  // ---------------------------------------------------------------------------
  prbs9_lfsr u_lfsr (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_shift_en (strobe),
    .i_load_ext (state_q == ST_SEARCH),
    .i_ext_bit  (decision),
    .o_state    (lfsr_state),
    .o_pred     (pred)
  );

  assign mismatch  = decision ^ pred;
  // An all-zero register predicts zero forever; matches against it would let
  // a constant positive input lock, so they are not counted.
  assign lfsr_zero = (lfsr_state == '0);

  // ---------------------------------------------------------------------------
  // FSM and counters: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    bit_d      = bit_q;
    err_d      = err_q;
    last_err_d = last_err_q;
`ifdef DEMOD_BER_AUTO_RELOCK_EN
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
`endif

    if (strobe) begin
      last_err_d = mismatch;
      unique case (state_q)
        ST_SEARCH: begin
          if (lfsr_zero || mismatch) begin
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
          if (match_d == MATCH_W'(LOCK_THR)) begin
            // Lock entry starts a fresh measurement.
            state_d = ST_LOCK;
            match_d = '0;
            bit_d   = '0;
            err_d   = '0;
`ifdef DEMOD_BER_AUTO_RELOCK_EN
            win_bits_d = '0;
            win_errs_d = '0;
`endif
          end
        end

        ST_LOCK: begin
          if (bit_q != CNT_MAX) begin
            bit_d = bit_q + 1'b1;
          end
          if (mismatch && (err_q != CNT_MAX)) begin
            err_d = err_q + 1'b1;
          end
`ifdef DEMOD_BER_AUTO_RELOCK_EN
          win_bits_d = win_bits_q + 1'b1;
          win_errs_d = win_errs_q + WIN_W'(mismatch);
          if (win_bits_d == WIN_W'(WIN)) begin
            // Window closes: too many errors means alignment is gone.
            if (win_errs_d >= WIN_W'(LOSS_THR)) begin
              state_d = ST_SEARCH;
              match_d = '0;
            end
            win_bits_d = '0;
            win_errs_d = '0;
          end
`endif
        end

        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end

    // Sticky: once either counter hits all-ones the flag stays until reset,
    // even across a later lock entry that clears the counters.
    sat_d = sat_q | (bit_d == CNT_MAX) | (err_d == CNT_MAX);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_SEARCH;
      phase_q    <= '0;
      match_q    <= '0;
      bit_q      <= '0;
      err_q      <= '0;
      last_err_q <= 1'b0;
      sat_q      <= 1'b0;
`ifdef DEMOD_BER_AUTO_RELOCK_EN
      win_bits_q <= '0;
      win_errs_q <= '0;
`endif
    end else if (i_enable) begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      match_q    <= match_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
      sat_q      <= sat_d;
`ifdef DEMOD_BER_AUTO_RELOCK_EN
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, one cycle after the strobe sample
  // ---------------------------------------------------------------------------
  assign o_lock    = (state_q == ST_LOCK);
  assign o_bit_cnt = bit_q;
  assign o_err_cnt = err_q;

  always_comb begin
    o_leds               = '0;
    o_leds[LED_LOCK]     = (state_q == ST_LOCK);
    o_leds[LED_LAST_ERR] = last_err_q;
    o_leds[LED_ERR_NZ]   = (err_q != '0);
    o_leds[LED_SAT]      = sat_q;
  end

endmodule : demod_ber

// File: tb/tb_demod_ber.sv
// -----------------------------------------------------------------------------
// tb_demod_ber -- scoreboard bench for demod_ber.
//
// Two DUTs share all inputs: one with 32-bit counters, one with 4-bit
// counters. Stimulus pushes the expected outputs (from a sequence-level PRBS9
// model) into a queue each cycle; an independent monitor pops and compares
// after every rising edge. A few directed checks cover the headline cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_demod_ber;

  localparam int OS_P     = 4;
  localparam int NB_P     = 8;
  localparam int LOCK_THR = 32;
  localparam int WIN_P    = 64;
  localparam int LOSS_THR = 16;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [1:0]  i_phase;
  logic [7:0]  i_sample;

  logic        lock32, lock4;
  logic [31:0] bit32, err32;
  logic [3:0]  bit4, err4;
  logic [3:0]  leds32, leds4;

  always #5 clock = ~clock;

  demod_ber #(.OS(OS_P), .NB(NB_P), .CNT_W(32), .LOCK_THR(LOCK_THR),
              .WIN(WIN_P), .LOSS_THR(LOSS_THR)) u_dut32 (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_phase   (i_phase),
    .i_sample  (i_sample),
    .o_lock    (lock32),
    .o_bit_cnt (bit32),
    .o_err_cnt (err32),
    .o_leds    (leds32)
  );

  demod_ber #(.OS(OS_P), .NB(NB_P), .CNT_W(4), .LOCK_THR(LOCK_THR),
              .WIN(WIN_P), .LOSS_THR(LOSS_THR)) u_dut4 (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_phase   (i_phase),
    .i_sample  (i_sample),
    .o_lock    (lock4),
    .o_bit_cnt (bit4),
    .o_err_cnt (err4),
    .o_leds    (leds4)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on the bit sequence, not on hardware registers.
  // ref_bits holds the last nine reference bits, oldest first; the PRBS9
  // recurrence predicts b[n] = b[n-9] ^ b[n-5]. Counts are kept unbounded and
  // clipped to each counter width when the expectation is formed.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit     lock;
    longint bits;
    longint errs;
    bit     last_err;
    bit     sat32;
    bit     sat4;
  } exp_t;

  exp_t   exp_q[$];
  bit     ref_bits[$];
  bit     m_locked;
  int     m_pc;
  int     m_match;
  longint m_bits, m_errs;
  bit     m_last, m_sat32, m_sat4;
  int     m_wb, m_we;
  int     cur_phase;

  function automatic longint clip(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    ref_bits.delete();
    for (int i = 0; i < 9; i++) ref_bits.push_back(1'b0);
    m_locked = 0; m_pc = 0; m_match = 0; m_bits = 0; m_errs = 0;
    m_last = 0; m_sat32 = 0; m_sat4 = 0; m_wb = 0; m_we = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit en, input int ph,
                                     input logic [7:0] s);
    bit   strobe, d, pred, err, all_zero;
    exp_t e;
    if (rst) begin
      model_reset();
    end else if (en) begin
      strobe = (m_pc == ph);
      m_pc   = (m_pc + 1) % OS_P;
      if (strobe) begin
        d        = ($signed(s) < 0);
        pred     = ref_bits[0] ^ ref_bits[4];
        err      = (d != pred);
        all_zero = 1;
        foreach (ref_bits[i]) if (ref_bits[i]) all_zero = 0;
        m_last = err;
        if (!m_locked) begin
          ref_bits.push_back(d);
          ref_bits.delete(0);
          m_match = (all_zero || err) ? 0 : m_match + 1;
          if (m_match == LOCK_THR) begin
            m_locked = 1; m_bits = 0; m_errs = 0; m_wb = 0; m_we = 0;
          end
        end else begin
          ref_bits.push_back(pred);
          ref_bits.delete(0);
          m_bits++;
          if (err) m_errs++;
`ifdef DEMOD_BER_AUTO_RELOCK_EN
          m_wb++;
          if (err) m_we++;
          if (m_wb == WIN_P) begin
            if (m_we >= LOSS_THR) begin
              m_locked = 0;
              m_match  = 0;
            end
            m_wb = 0;
            m_we = 0;
          end
`endif
        end
        if (clip(m_bits, 32) == 64'hFFFF_FFFF || clip(m_errs, 32) == 64'hFFFF_FFFF)
          m_sat32 = 1;
        if (clip(m_bits, 4) == 15 || clip(m_errs, 4) == 15)
          m_sat4 = 1;
      end
    end
    e.lock = m_locked; e.bits = m_bits; e.errs = m_errs;
    e.last_err = m_last; e.sat32 = m_sat32; e.sat4 = m_sat4;
    exp_q.push_back(e);
  endfunction

  // Independent PRBS9 source (x^9 + x^5 + 1), seeded all-ones.
  bit gen_q[$];

  function automatic bit prbs_next();
    bit b;
    b = gen_q[0] ^ gen_q[4];
    gen_q.push_back(b);
    gen_q.delete(0);
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge
  // ---------------------------------------------------------------------------
  task automatic drive(input bit rst, input bit en, input logic [7:0] s);
    @(negedge clock);
    i_reset  = rst;
    i_enable = en;
    i_phase  = 2'(cur_phase);
    i_sample = s;
    model_step(rst, en, cur_phase, s);
  endtask

  // One symbol: the strobe cycle carries +/-amp, other cycles carry noise
  // (noisy=1) or the same +amp level (noisy=0).
  task automatic send_symbol(input bit b, input int amp, input bit noisy);
    bit         hit;
    logic [7:0] s;
    hit = 0;
    while (!hit) begin
      hit = (m_pc == cur_phase);
      if (hit)        s = b ? 8'(-amp) : 8'(amp);
      else if (noisy) s = 8'($urandom);
      else            s = 8'(amp);
      drive(1'b0, 1'b1, s);
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per clock and compares both DUTs
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lock32",  64'(lock32), 64'(e.lock));
        check("bit32",   64'(bit32),  clip(e.bits, 32));
        check("err32",   64'(err32),  clip(e.errs, 32));
        check("leds32",  64'(leds32), 64'({e.sat32, e.errs != 0, e.last_err, e.lock}));
        check("lock4",   64'(lock4),  64'(e.lock));
        check("bit4",    64'(bit4),   clip(e.bits, 4));
        check("err4",    64'(err4),   clip(e.errs, 4));
        check("leds4",   64'(leds4),  64'({e.sat4, e.errs != 0, e.last_err, e.lock}));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    bit b;
    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_phase   = 2'd2;
    i_sample  = '0;
    cur_phase = 2;
    model_reset();
    for (int i = 0; i < 9; i++) gen_q.push_back(1'b1);

    // Reset, including reset with enable high.
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h80);

    // Aligned PRBS9 at +/-64 on phase 2: lock within 32+9 symbols, no errors.
    for (int i = 0; i < 41; i++) send_symbol(prbs_next(), 64, 1'b1);
    settle();
    check("lock_after_41_symbols", 64'(lock32), 64'd1);
    check("err_zero_at_lock",      64'(err32),  64'd0);

    // One inverted symbol per 100: one error per 100 bits, lock held.
    for (int i = 0; i < 300; i++) begin
      b = prbs_next();
      if (i % 100 == 50) b = ~b;
      send_symbol(b, 64, 1'b1);
    end
    settle();
    check("err_after_3_injections", 64'(err32),  64'd3);
    check("lock_during_injection",  64'(lock32), 64'd1);

    // Random bits in place of the stream (generator keeps advancing).
    for (int i = 0; i < 130; i++) begin
      void'(prbs_next());
      send_symbol(1'($urandom), 64, 1'b1);
    end
    settle();
`ifdef DEMOD_BER_AUTO_RELOCK_EN
    check("lock_lost_after_random", 64'(lock32), 64'd0);
`else
    check("lock_kept_after_random", 64'(lock32), 64'd1);
`endif

    // Clean stream again: relocks (or stays locked).
    for (int i = 0; i < 60; i++) send_symbol(prbs_next(), 64, 1'b1);

    // Enable low mid-lock: everything frozen.
    repeat (50) drive(1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) send_symbol(prbs_next(), 64, 1'b1);

    // Reset pulse mid-lock: all outputs zero on the next cycle.
    drive(1'b1, 1'b1, 8'h9c);
    settle();
    check("reset_lock",    64'(lock32), 64'd0);
    check("reset_bit_cnt", 64'(bit32),  64'd0);
    check("reset_err_cnt", 64'(err32),  64'd0);
    check("reset_leds",    64'(leds32), 64'd0);

    // Constant +100 for 500 symbols: never locks.
    for (int i = 0; i < 500; i++) send_symbol(1'b0, 100, 1'b0);
    settle();
    check("const_input_no_lock", 64'(lock32), 64'd0);
    check("const_input_bits0",   64'(bit32),  64'd0);

    // Lock at phase 1, then move to phase 3 mid-lock without a counter reset.
    cur_phase = 1;
    for (int i = 0; i < 50; i++) send_symbol(prbs_next(), 64, 1'b1);
    cur_phase = 3;
    for (int i = 0; i < 30; i++) send_symbol(prbs_next(), 64, 1'b1);
    settle();
    check("phase_change_lock",   64'(lock32), 64'd1);
    check("phase_change_err0",   64'(err32),  64'd0);
    check("sat4_bit_cnt",        64'(bit4),   64'd15);
    check("sat4_led3",           64'(leds4[3]), 64'd1);
    check("no_sat32_led3",       64'(leds32[3]), 64'd0);

    // Let the monitor drain the scoreboard.
    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demod_ber
